// File: rtl/flee_ejector.sv
// -----------------------------------------------------------------------------
// flee_ejector
//
// Ejection stage for one flee output port. Accepted flits are buffered in a
// 2-entry FIFO toward the local consumer. Wormhole framing (head/body/tail) is
// checked on the way in, and flit, packet and error counters are kept.
//
// Optional feature: define FLEE_WDOG_EN to build a watchdog. It raises a sticky
// stall flag when the port sits mid-packet without accepting a flit for
// WDOG_CYCLES cycles. When FLEE_WDOG_EN is not defined, stall_o is tied to 0.
//
// Parameters:
//   DW           flit width; bits [DW-1:DW-2] carry the flit type
//   CNT_W        width of every counter (counters wrap silently)
//   WDOG_CYCLES  stall threshold in cycles (>= 2), used with FLEE_WDOG_EN only
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   data_i      flit from the network port
//   valid_i     flit valid from the network port
//   ready_o     space available (FIFO not full)
//   data_o      FIFO head flit to the local consumer
//   valid_o     FIFO head valid
//   ready_i     consumer accepts the head flit
//   flit_cnt_o  accepted flits
//   pkt_cnt_o   completed packets
//   err_cnt_o   framing violations
//   err_o       sticky framing-violation flag
//   stall_o     sticky watchdog flag
// -----------------------------------------------------------------------------
`ifndef DW
`define DW 16
`endif

module flee_ejector #(
    parameter int DW          = `DW,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [DW-1:0]    data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] flit_cnt_o,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             err_o,
    output logic             stall_o
);

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t           state_r;
    logic [DW-1:0]    mem0_r;
    logic [DW-1:0]    mem1_r;
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic [CNT_W-1:0] flit_cnt_r;
    logic [CNT_W-1:0] pkt_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic             err_r;

    logic       push_s;
    logic       pop_s;
    logic [1:0] ftype_s;

    // Handshakes derive only from the registered occupancy, so there is no
    // combinational path from valid_i to ready_o.
    assign ready_o = (count_r != 2'd2);
    assign valid_o = (count_r != 2'd0);
    assign data_o  = rd_ptr_r ? mem1_r : mem0_r;
    assign push_s  = valid_i & ready_o;
    assign pop_s   = valid_o & ready_i;
    assign ftype_s = data_i[DW-1:DW-2];

    assign flit_cnt_o = flit_cnt_r;
    assign pkt_cnt_o  = pkt_cnt_r;
    assign err_cnt_o  = err_cnt_r;
    assign err_o      = err_r;

    // Two-entry FIFO storage, pointers and occupancy. There is no bypass: a
    // flit pushed into an empty FIFO becomes visible in the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0_r   <= '0;
            mem1_r   <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                if (wr_ptr_r) begin
                    mem1_r <= data_i;
                end else begin
                    mem0_r <= data_i;
                end
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Framing FSM and the flit, packet and error counters. All of them advance
    // only on an accepted flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            flit_cnt_r <= '0;
            pkt_cnt_r  <= '0;
            err_cnt_r  <= '0;
            err_r      <= 1'b0;
        end else if (push_s) begin
            flit_cnt_r <= flit_cnt_r + CNT_ONE;
            case (state_r)
                S_IDLE: begin
                    case (ftype_s)
                        T_HEAD:   state_r <= S_BODY;
                        T_SINGLE: pkt_cnt_r <= pkt_cnt_r + CNT_ONE;
                        default: begin
                            // BODY or TAIL without an open packet
                            err_cnt_r <= err_cnt_r + CNT_ONE;
                            err_r     <= 1'b1;
                        end
                    endcase
                end
                S_BODY: begin
                    case (ftype_s)
                        T_BODY: state_r <= S_BODY;
                        T_TAIL: begin
                            state_r   <= S_IDLE;
                            pkt_cnt_r <= pkt_cnt_r + CNT_ONE;
                        end
                        T_HEAD: begin
                            // Truncated packet. The new head opens a fresh
                            // packet, so the FSM stays in BODY.
                            err_cnt_r <= err_cnt_r + CNT_ONE;
                            err_r     <= 1'b1;
                        end
                        default: begin
                            // SINGLE inside a packet closes it as a packet.
                            state_r   <= S_IDLE;
                            pkt_cnt_r <= pkt_cnt_r + CNT_ONE;
                            err_cnt_r <= err_cnt_r + CNT_ONE;
                            err_r     <= 1'b1;
                        end
                    endcase
                end
                default: state_r <= S_IDLE;
            endcase
        end else begin
            state_r <= state_r;
        end
    end

`ifdef FLEE_WDOG_EN
    localparam int                WDOG_W   = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1);

    logic [WDOG_W-1:0] wdog_r;
    logic              stall_r;

    // Watchdog: counts cycles spent mid-packet without an accept and saturates
    // at the threshold. The flag is raised on the edge where the count reaches
    // the threshold, and it stays set until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_r  <= '0;
            stall_r <= 1'b0;
        end else if (push_s || (state_r == S_IDLE)) begin
            wdog_r <= '0;
        end else if (wdog_r != WDOG_LIM) begin
            wdog_r <= wdog_r + WDOG_ONE;
            if (wdog_r == (WDOG_LIM - WDOG_ONE)) begin
                stall_r <= 1'b1;
            end
        end else begin
            wdog_r <= wdog_r;
        end
    end

    assign stall_o = stall_r;
`else
    // Without the watchdog the threshold has no effect, and the flag stays 0.
    assign stall_o = 1'b0 & (WDOG_CYCLES >= 2);
`endif

endmodule

// File: tb/tb_flee_ejector.sv
// -----------------------------------------------------------------------------
// tb_flee_ejector
//
// Testbench for flee_ejector. It runs directed framing, backpressure and reset
// scenarios, followed by randomized traffic. Every cycle, the DUT is compared
// against a behavioural model built from a flit queue, an in-packet flag and
// plain counters.
// -----------------------------------------------------------------------------
module tb_flee_ejector;

    localparam int DW = 16;
    localparam int CW = 32;
    localparam int WD = 16;

    localparam logic [1:0] BODY   = 2'b00;
    localparam logic [1:0] TAIL   = 2'b01;
    localparam logic [1:0] HEAD   = 2'b10;
    localparam logic [1:0] SINGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] flit_cnt_o;
    logic [CW-1:0] pkt_cnt_o;
    logic [CW-1:0] err_cnt_o;
    logic          err_o;
    logic          stall_o;

    always #5 clk = ~clk;

    flee_ejector #(
        .DW          (DW),
        .CNT_W       (CW),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .flit_cnt_o (flit_cnt_o),
        .pkt_cnt_o  (pkt_cnt_o),
        .err_cnt_o  (err_cnt_o),
        .err_o      (err_o),
        .stall_o    (stall_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [DW-1:0] q[$];
    int unsigned   m_flit;
    int unsigned   m_pkt;
    int unsigned   m_err;
    bit            m_errf;
    bit            m_in;
    bit            m_stall;
    int            m_wd;
    bit            last_acc;
    logic [13:0]   seq = 14'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("ready", ready_o, (q.size() < 2));
        check("valid", valid_o, (q.size() > 0));
        if (q.size() > 0) begin
            check("data", data_o, q[0]);
        end
        check("flit_cnt", flit_cnt_o, m_flit);
        check("pkt_cnt", pkt_cnt_o, m_pkt);
        check("err_cnt", err_cnt_o, m_err);
        check("err", err_o, m_errf);
        check("stall", stall_o, m_stall);
    endtask

    task automatic model_reset();
        q.delete();
        m_flit  = 0;
        m_pkt   = 0;
        m_err   = 0;
        m_errf  = 1'b0;
        m_in    = 1'b0;
        m_stall = 1'b0;
        m_wd    = 0;
    endtask

    // one clock: evaluate the model on the inputs present before the edge,
    // then compare the DUT on the following falling edge
    task automatic cycle();
        bit            pp;
        logic [DW-1:0] d;
        logic [1:0]    t;
        last_acc = valid_i && (q.size() < 2);
        pp       = ready_i && (q.size() > 0);
        d        = data_i;
        @(posedge clk);
        if (pp) void'(q.pop_front());
`ifdef FLEE_WDOG_EN
        if (last_acc || !m_in) begin
            m_wd = 0;
        end else if (m_wd < WD) begin
            m_wd++;
            if (m_wd == WD) m_stall = 1'b1;
        end
`endif
        if (last_acc) begin
            q.push_back(d);
            m_flit++;
            t = d[DW-1:DW-2];
            if (!m_in) begin
                if (t == HEAD) m_in = 1'b1;
                else if (t == SINGLE) m_pkt++;
                else begin m_err++; m_errf = 1'b1; end
            end else begin
                case (t)
                    TAIL:    begin m_in = 1'b0; m_pkt++; end
                    HEAD:    begin m_err++; m_errf = 1'b1; end
                    SINGLE:  begin m_err++; m_errf = 1'b1; m_in = 1'b0; m_pkt++; end
                    default: ;
                endcase
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [1:0] t, input bit rdy);
        data_i  = {t, seq};
        seq     = seq + 14'd1;
        valid_i = 1'b1;
        ready_i = rdy;
        last_acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_acc) break;
        end
        check("send_timeout", last_acc, 1'b1);
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        ready_i = 1'b0;
        rst     = 1'b1;
        #1;
        model_reset();
        check("rst_valid", valid_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        check("rst_data", data_o, 16'h0000);
        check("rst_flit", flit_cnt_o, 32'd0);
        check("rst_pkt", pkt_cnt_o, 32'd0);
        check("rst_errc", err_cnt_o, 32'd0);
        check("rst_err", err_o, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // back-to-back packet with the consumer always ready
        send(HEAD, 1'b1);
        repeat (3) send(BODY, 1'b1);
        send(TAIL, 1'b1);
        repeat (2) cycle();
        check("t1_flit", flit_cnt_o, 32'd5);
        check("t1_pkt", pkt_cnt_o, 32'd1);
        check("t1_err", err_o, 1'b0);

        // backpressure: two accepted, then full until a pop
        do_reset();
        send(HEAD, 1'b0);
        send(BODY, 1'b0);
        data_i  = {BODY, seq};
        valid_i = 1'b1;
        cycle();
        check("t2_full", ready_o, 1'b0);
        cycle();
        check("t2_held", flit_cnt_o, 32'd2);
        send(BODY, 1'b1);
        send(TAIL, 1'b1);
        repeat (3) cycle();
        check("t2_flit", flit_cnt_o, 32'd4);
        check("t2_pkt", pkt_cnt_o, 32'd1);
        check("t2_empty", valid_o, 1'b0);

        // orphan BODY, then SINGLE from IDLE
        do_reset();
        send(BODY, 1'b1);
        check("t3_errc", err_cnt_o, 32'd1);
        check("t3_err", err_o, 1'b1);
        send(SINGLE, 1'b1);
        check("t3_pkt", pkt_cnt_o, 32'd1);
        check("t3_errc2", err_cnt_o, 32'd1);

        // truncated packet: HEAD BODY HEAD TAIL
        do_reset();
        send(HEAD, 1'b1);
        send(BODY, 1'b1);
        send(HEAD, 1'b1);
        send(TAIL, 1'b1);
        check("t4_errc", err_cnt_o, 32'd1);
        check("t4_pkt", pkt_cnt_o, 32'd1);
        check("t4_flit", flit_cnt_o, 32'd4);

`ifdef FLEE_WDOG_EN
        // 16 idle cycles mid-packet raise the stall flag
        do_reset();
        send(HEAD, 1'b1);
        repeat (15) cycle();
        check("wd_before", stall_o, 1'b0);
        cycle();
        check("wd_fire", stall_o, 1'b1);
        send(TAIL, 1'b1);
        check("wd_sticky", stall_o, 1'b1);
        // a 15-cycle gap stays below the threshold
        do_reset();
        send(HEAD, 1'b1);
        repeat (15) cycle();
        send(TAIL, 1'b1);
        repeat (20) cycle();
        check("wd_short", stall_o, 1'b0);
`endif

        // reset in mid-packet with two flits buffered
        do_reset();
        send(HEAD, 1'b0);
        send(BODY, 1'b0);
        check("t6_buf", valid_o, 1'b1);
        do_reset();
        send(BODY, 1'b1);
        check("t6_errc", err_cnt_o, 32'd1);
        check("t6_err", err_o, 1'b1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            data_i  = {2'($urandom_range(0, 3)), seq};
            seq     = seq + 14'd1;
            cycle();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flee_ejector.md
# flee_ejector

Ejection stage attached to one `flee` output port of the network `system`. It consumes flits from the port, checks wormhole framing (head/body/tail), buffers them in a 2-entry FIFO toward the local consumer, and keeps flit, packet and error counters. An optional watchdog flags a stalled mid-packet port, so the same stall detection that simulation does at the bench is available in RTL.

## Interface
- `DW`, default `` `DW `` (from params.svh): flit width; bits `[DW-1:DW-2]` are the flit type.
- `CNT_W`, default 32: width of every counter.
- `WDOG_CYCLES`, default 10000: stall threshold in cycles; must be ≥ 2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_i`  in  DW  flit from `data_o_fleeN`.
- `valid_i`  in  1  from `valid_o_fleeN`.
- `ready_o`  out  1  to `ready_i_fleeN`.
- `data_o`  out  DW  flit to local consumer.
- `valid_o`  out  1  FIFO head valid.
- `ready_i`  in  1  consumer accepts.
- `flit_cnt_o`  out  CNT_W  accepted flits.
- `pkt_cnt_o`  out  CNT_W  completed packets (tail or single accepted in a legal position).
- `err_cnt_o`  out  CNT_W  framing violations.
- `err_o`  out  1  sticky, set on first framing violation.
- `stall_o`  out  1  sticky watchdog flag (0 when watchdog compiled out).

## Operation
- Flit types: `2'b10` HEAD, `2'b00` BODY, `2'b01` TAIL, `2'b11` SINGLE (head+tail).
- Input accept = `valid_i & ready_o`; `ready_o` = FIFO not full (count < 2), combinational from registered count only.
- Every accepted flit is written to the FIFO unchanged, including illegal ones; `flit_cnt_o` +1.
- Framing FSM, states IDLE and BODY (reset IDLE):
  - IDLE + HEAD -> BODY. IDLE + SINGLE -> IDLE, `pkt_cnt_o` +1.
  - IDLE + BODY or TAIL -> violation, stay IDLE.
  - BODY + BODY -> BODY. BODY + TAIL -> IDLE, `pkt_cnt_o` +1.
  - BODY + HEAD -> violation, stay BODY (new packet begins). BODY + SINGLE -> violation, IDLE, `pkt_cnt_o` +1.
- Violation: `err_cnt_o` +1, `err_o` <= 1.
- FSM and counters advance only on accept.
- FIFO: 2 entries, write pointer / read pointer / 2-bit count. Output pop = `valid_o & ready_i`. Simultaneous push and pop at count 2 impossible (ready_o=0); at count 1 or 0 count unchanged / +1 as normal. Pop with push at count 0: the pushed flit becomes visible next cycle (no bypass).
- Counters wrap modulo 2^CNT_W silently.

## Timing
- Reset values: `ready_o`=1 after reset deasserts (0 never needed during reset; output held at 1 as count=0), `valid_o`=0, `data_o`=0, all counters 0, `err_o`=0, `stall_o`=0, FSM IDLE.
- Latency: flit accepted in cycle t appears on `data_o` with `valid_o`=1 in cycle t+1.
- Throughput: 1 flit/cycle with `ready_i` held 1. With `ready_i`=0, exactly 2 flits accepted, then `ready_o`=0 until a pop.
- `valid_o` and `data_o` stable while `valid_o & ~ready_i`.
- Counters/`err_o` update on the clock edge of the accept, visible cycle t+1.
- `rst` asserted mid-packet: FIFO emptied, FSM IDLE, counters and flags cleared immediately (asynchronous); subsequent BODY flit is a violation.

## Configuration
- `FLEE_WDOG_EN` defined: watchdog counter (width ceil(log2(WDOG_CYCLES+1))) increments each cycle FSM is BODY with no accept; clears on any accept or on FSM IDLE. On reaching `WDOG_CYCLES`, `stall_o` <= 1 (sticky until `rst`); counter saturates.
- Undefined: no watchdog logic, `stall_o` tied 0.

## Test plan
- Reset, then HEAD, BODY×3, TAIL back-to-back, `ready_i`=1 -> flits out in order 1 cycle later, `flit_cnt_o`=5, `pkt_cnt_o`=1, `err_o`=0.
- `ready_i`=0, 4 flits offered -> 2 accepted, `ready_o`=0 from cycle 2; `ready_i`=1 -> remaining drain, order preserved, no loss/duplication.
- BODY first after reset -> `err_cnt_o`=1, `err_o`=1, FSM IDLE; then SINGLE -> `pkt_cnt_o`=1.
- HEAD, BODY, HEAD, TAIL -> `err_cnt_o`=1, `pkt_cnt_o`=1, `flit_cnt_o`=4.
- `FLEE_WDOG_EN`, `WDOG_CYCLES`=16: HEAD then `valid_i`=0 for 16 cycles -> `stall_o`=1 in cycle 17, stays 1 after TAIL; 15-cycle gap -> `stall_o` stays 0.
- `rst` pulsed after HEAD with 2 flits buffered -> `valid_o`=0, counters 0 same cycle; next BODY flagged as violation.
